jellyvl_fifo_async_wr_ptr: RTL and testbench

Write-side pointer and flow-control stage of an asynchronous FIFO, running entirely in the write clock domain. It accepts write requests, produces the RAM write address, and maintains a binary write pointer that advances by exactly one per accepted word. That pointer feeds a gray-code CDC stage toward the read domain. The block also consumes the read pointer that the opposite gray-code CDC stage has already synchronized into this domain, and from it derives full, almost-full, free count and a pointer-consistency error.

---
 rtl/jellyvl_fifo_async_wr_ptr.sv | 108 ++++++++++
 tb/tb_jellyvl_fifo_async_wr_ptr.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/jellyvl_fifo_async_wr_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : jellyvl_fifo_async_wr_ptr
//  Purpose  : Write-side pointer and flow-control stage of an asynchronous
//             FIFO. Everything here runs in the write clock domain. The block
//             accepts write requests, produces the RAM write address and keeps
//             a binary write pointer that moves by at most one per clock, so it
//             can feed a gray-code CDC stage toward the read domain. It also
//             takes the read pointer that has already been synchronized into
//             this domain, and derives full, almost-full, free count and a
//             sticky pointer-consistency error from it.
//  Ports    : reset       - synchronous active-high reset
//             clk         - write-domain clock
//             s_valid     - write request
//             s_ready     - a write can be accepted this cycle
//             wr_en       - RAM write enable (s_valid & s_ready)
//             wr_addr     - RAM write address (low bits of the write pointer)
//             wptr_bin    - registered binary write pointer (to gray CDC)
//             rptr_bin    - synchronized binary read pointer (from gray CDC)
//             free_count  - free words, 0..DEPTH
//             full        - no free words
//             almost_full - free_count <= ALMOST_FULL_FREE
//             ptr_error   - sticky pointer-inconsistency flag
//  Revision : 1.0 - initial release
// ============================================================================
module jellyvl_fifo_async_wr_ptr #(
    parameter int PTR_WIDTH        = 5,
    parameter int ALMOST_FULL_FREE = 2
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 wr_en,
    output logic [PTR_WIDTH-1:0] wr_addr,
    output logic [PTR_WIDTH:0]   wptr_bin,
    input  logic [PTR_WIDTH:0]   rptr_bin,
    output logic [PTR_WIDTH:0]   free_count,
    output logic                 full,
    output logic                 almost_full,
    output logic                 ptr_error
);

    localparam logic [PTR_WIDTH:0] c_DEPTH  = (PTR_WIDTH+1)'(1) << PTR_WIDTH;
    // almost_full out of reset: only true if the threshold covers the whole FIFO
    localparam logic               c_AF_RST = ((1 << PTR_WIDTH) <= ALMOST_FULL_FREE);

    logic [PTR_WIDTH:0] r_wptr;
    logic [PTR_WIDTH:0] r_free_count;
    logic               r_full;
    logic               r_almost_full;
    logic               r_ptr_error;

    logic               w_accept;
    logic [PTR_WIDTH:0] w_wptr_next;
    logic [PTR_WIDTH:0] w_used_next;
    logic [PTR_WIDTH:0] w_free_next;
    logic               w_overrun;

    // The synchronized read pointer is used directly in the next-state
    // occupancy; its registered copy is exactly what the free count, full and
    // almost-full flops capture, so the one-clock latency is preserved without
    // keeping a separate read-pointer register.
    always_comb begin
        w_accept    = s_valid & s_ready;
        w_wptr_next = r_wptr + {{PTR_WIDTH{1'b0}}, w_accept};
        // Modulo 2**(PTR_WIDTH+1) difference; wraps naturally with the width.
        w_used_next = w_wptr_next - rptr_bin;
        // More than DEPTH words in use means the read side is ahead of the
        // write side or went backwards: the pointers are inconsistent.
        w_overrun   = (w_used_next > c_DEPTH);
        w_free_next = c_DEPTH - w_used_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr        <= '0;
            r_free_count  <= c_DEPTH;
            r_full        <= 1'b0;
            r_almost_full <= c_AF_RST;
            r_ptr_error   <= 1'b0;
        end else begin
            r_wptr <= w_wptr_next;
            if (r_ptr_error || w_overrun) begin
                // Once inconsistent, stay locked in the "full" state until reset.
                r_ptr_error   <= 1'b1;
                r_free_count  <= '0;
                r_full        <= 1'b1;
                r_almost_full <= 1'b1;
            end else begin
                r_free_count  <= w_free_next;
                r_full        <= (w_used_next == c_DEPTH);
                r_almost_full <= (32'(w_free_next) <= ALMOST_FULL_FREE);
            end
        end
    end

    assign s_ready     = ~r_full & ~r_ptr_error;
    assign wr_en       = w_accept;
    assign wptr_bin    = r_wptr;
    assign wr_addr     = r_wptr[PTR_WIDTH-1:0];
    assign free_count  = r_free_count;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign ptr_error   = r_ptr_error;

endmodule
`default_nettype wire

// File: tb/tb_jellyvl_fifo_async_wr_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jellyvl_fifo_async_wr_ptr
//  Purpose  : Self-checking bench for jellyvl_fifo_async_wr_ptr. A behavioural
//             model tracks how many words have been written and where the
//             reader is, and predicts the flags from occupancy arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jellyvl_fifo_async_wr_ptr;

    localparam int PW    = 5;
    localparam int DEPTH = 1 << PW;
    localparam int MOD   = 2 * DEPTH;
    localparam int AFF   = 2;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [PW:0]   wptr_bin;
    logic [PW:0]   rptr_bin;
    logic [PW:0]   free_count;
    logic          full;
    logic          almost_full;
    logic          ptr_error;

    jellyvl_fifo_async_wr_ptr #(
        .PTR_WIDTH        (PW),
        .ALMOST_FULL_FREE (AFF)
    ) u_dut (
        .reset       (reset),
        .clk         (clk),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wptr_bin    (wptr_bin),
        .rptr_bin    (rptr_bin),
        .free_count  (free_count),
        .full        (full),
        .almost_full (almost_full),
        .ptr_error   (ptr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: total words written (modulo pointer range), reader
    // position, and whether the pointers were ever seen to be inconsistent.
    int m_written;
    int m_read;
    bit m_err;
    int m_writes_seen;

    function automatic int m_free();
        int used;
        used = ((m_written - m_read) % MOD + MOD) % MOD;
        if (m_err) return 0;
        return DEPTH - used;
    endfunction

    function automatic bit m_ready();
        return (m_free() != 0) && !m_err;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".wptr_bin"},    32'(wptr_bin),    32'(m_written % MOD));
        check({tag, ".wr_addr"},     32'(wr_addr),     32'(m_written % DEPTH));
        check({tag, ".free_count"},  32'(free_count),  32'(m_free()));
        check({tag, ".full"},        32'(full),        32'(m_free() == 0));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(m_free() <= AFF));
        check({tag, ".ptr_error"},   32'(ptr_error),   32'(m_err));
        check({tag, ".s_ready"},     32'(s_ready),     32'(m_ready()));
    endtask

    // One clock: drive inputs, check the combinational write enable, take the
    // edge, update the model, then check every registered output.
    task automatic step(input logic rst_i, input logic v, input int r, input string tag);
        bit acc;
        int used;
        reset    = rst_i;
        s_valid  = v;
        rptr_bin = (PW+1)'(r % MOD);
        #1;
        acc = 1'b0;
        if (!rst_i) begin
            acc = v && m_ready();
            check({tag, ".wr_en"}, 32'(wr_en), 32'(acc));
        end
        @(posedge clk);
        if (rst_i) begin
            m_written = 0;
            m_read    = 0;
            m_err     = 1'b0;
        end else begin
            if (acc) begin
                m_written     = (m_written + 1) % MOD;
                m_writes_seen = m_writes_seen + 1;
            end
            m_read = r % MOD;
            used   = ((m_written - m_read) % MOD + MOD) % MOD;
            if (used > DEPTH) m_err = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        int r;
        int avail;
        reset         = 1'b1;
        s_valid       = 1'b0;
        rptr_bin      = '0;
        m_written     = 0;
        m_read        = 0;
        m_err         = 1'b0;
        m_writes_seen = 0;
        @(posedge clk);
        #1;

        // Reset held for two clocks
        step(1'b1, 1'b0, 0, "reset0");
        step(1'b1, 1'b0, 0, "reset1");
        check("reset.free_const", 32'(free_count), 32'(DEPTH));

        // Fill: continuous writer stops exactly at DEPTH words
        m_writes_seen = 0;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 0, "fill");
        check("fill.write_count", 32'(m_writes_seen), 32'(DEPTH));
        check("fill.wptr_const",  32'(wptr_bin),      32'(DEPTH));
        check("fill.full_const",  32'(full),          32'd1);

        // Drain release: reader frees one slot, next write fills it again
        step(1'b0, 1'b0, 1, "release");
        check("release.free_const", 32'(free_count), 32'd1);
        step(1'b0, 1'b1, 1, "refill");
        check("refill.wptr_const", 32'(wptr_bin), 32'(DEPTH + 1));

        // Randomized: reader advances by a random amount that never overtakes
        for (int i = 0; i < 300; i++) begin
            avail = ((m_written - m_read) % MOD + MOD) % MOD;
            r     = (m_read + int'($urandom_range(0, avail))) % MOD;
            step(1'b0, 1'($urandom_range(0, 3) != 0), r, "random");
        end

        // Wrap: reader trails so exactly 3 words are always in use
        step(1'b1, 1'b0, 0, "wrap_rst");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0, "wrap_pre");
        for (int i = 0; i < 70; i++) begin
            step(1'b0, 1'b1, (m_written + MOD - 2) % MOD, "wrap");
            check("wrap.free_const", 32'(free_count), 32'(DEPTH - 3));
        end

        // Error: read pointer ahead of write pointer is sticky until reset
        step(1'b1, 1'b0, 0, "err_rst");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 0, "err_pre");
        step(1'b0, 1'b0, 12, "err_set");
        check("err.flag_const", 32'(ptr_error), 32'd1);
        step(1'b0, 1'b1, 10, "err_hold");
        step(1'b0, 1'b1, 10, "err_hold2");
        check("err.sticky_const", 32'(ptr_error), 32'd1);
        step(1'b1, 1'b0, 0, "err_clear");

        // Reset mid-stream discards the write presented in the reset cycle
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 0, "mid_pre");
        check("mid.wptr17_const", 32'(wptr_bin), 32'd17);
        step(1'b1, 1'b1, 0, "mid_rst");
        check("mid.wptr0_const", 32'(wptr_bin), 32'd0);
        step(1'b0, 1'b1, 0, "mid_post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
